// File: rtl/alu_share_arbiter_if.sv
// Request, response and ALU-side signal bundle for alu_share_arbiter.
// slave = arbiter view; master = requesters plus the shared ALU.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [OP_W-1:0]  req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [OP_W-1:0]  req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_data;

    logic [OP_W-1:0]  alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data,
        input  rsp0_ready, rsp1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_result
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data,
        output rsp0_ready, rsp1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_result
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one registered-output ALU between two requesters, one op in flight.
// Round-robin by default; define ALU_SHARE_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [OP_W-1:0]  r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_owner;

    logic [1:0]       w_req_valid;
    logic [1:0]       w_grant;
    logic [1:0]       w_req_ready;
    logic [1:0]       w_rsp_ready;
    logic [1:0]       w_rsp_valid;
    logic             w_accept;
    logic             w_accept_port;

    assign w_req_valid = {bus.req1_valid, bus.req0_valid};
    assign w_rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

`ifdef ALU_SHARE_FIXED_PRIO_EN
    assign w_grant[0] = w_req_valid[0];
    assign w_grant[1] = w_req_valid[1] & ~w_req_valid[0];
`else
    // r_prio = 1 means requester 1 is favoured on the next contention
    logic r_prio;

    assign w_grant[0] = w_req_valid[0] & (~w_req_valid[1] | ~r_prio);
    assign w_grant[1] = w_req_valid[1] & (~w_req_valid[0] |  r_prio);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_accept) begin
            r_prio <= ~w_accept_port;
        end
    end
`endif

    // Grants are one-hot, so grant[1] alone identifies the accepted port
    assign w_accept_port = w_grant[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 2'b00;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = w_grant;
                if (|w_grant) begin
                    w_accept     = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: w_state_next = S_CAPT;
            S_CAPT: w_state_next = S_RESP;
            S_RESP: begin
                if (w_rsp_ready[r_owner]) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operands stay put after the ALU samples them, until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_owner    <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= w_accept_port ? bus.req1_op : bus.req0_op;
                r_a     <= w_accept_port ? bus.req1_a  : bus.req0_a;
                r_b     <= w_accept_port ? bus.req1_b  : bus.req0_b;
                r_owner <= w_accept_port;
            end
            if (r_state == S_CAPT) begin
                r_rsp_data <= bus.alu_result;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign w_rsp_valid[gi] = (r_state == S_RESP) && (r_owner == (gi == 1));
    end

    assign bus.req0_ready = w_req_ready[0];
    assign bus.req1_ready = w_req_ready[1];
    assign bus.rsp0_valid = w_rsp_valid[0];
    assign bus.rsp1_valid = w_rsp_valid[1];
    assign bus.rsp_data   = r_rsp_data;
    assign bus.alu_op     = r_op;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a cycle-count transaction model.
module tb_alu_share_arbiter;
    localparam int W  = 32;
    localparam int OW = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_BAD  = 4'd15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(W), .OP_W(OW)) bus();

    alu_share_arbiter #(.WIDTH(W), .OP_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    // Shared ALU with one cycle of registered latency
    always @(posedge clk) bus.alu_result <= alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int txn    = 0;

    // Model: phase counts cycles since accept (0 = idle, 3 = response offered)
    int          m_phase;
    bit          m_owner;
    int          m_last;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_data;

    bit          g_acc0, g_acc1;
    bit          g_rdy0, g_rdy1;
    logic [31:0] g_rsp0, g_rsp1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_phase = 0; m_owner = 1'b0; m_last = 1;
        m_op = '0; m_a = '0; m_b = '0; m_data = '0;
        #1;
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_rsp0_valid", bus.rsp0_valid, 32'd0);
        check("rst_rsp1_valid", bus.rsp1_valid, 32'd0);
    endtask

    // One clock cycle: drive, check against model, clock, advance model
    task automatic step(input bit v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input bit v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input bit r0, input bit r1);
        bit e0, e1;
        bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
        bus.rsp0_ready = r0; bus.rsp1_ready = r1;
        #1;
        e0 = 1'b0; e1 = 1'b0;
        if (m_phase == 0) begin
            if (v0 && v1) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
                e0 = 1'b1;
`else
                if (m_last == 0) e1 = 1'b1;
                else             e0 = 1'b1;
`endif
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        g_rdy0 = bus.req0_ready;
        g_rdy1 = bus.req1_ready;
        check("req0_ready", bus.req0_ready, e0);
        check("req1_ready", bus.req1_ready, e1);
        check("rsp0_valid", bus.rsp0_valid, (m_phase == 3) && !m_owner);
        check("rsp1_valid", bus.rsp1_valid, (m_phase == 3) && m_owner);
        if (m_phase == 3) check("rsp_data", bus.rsp_data, m_data);
        check("alu_op", {28'd0, bus.alu_op}, {28'd0, m_op});
        check("alu_a", bus.alu_a, m_a);
        check("alu_b", bus.alu_b, m_b);
        @(posedge clk);
        cyc++;
        g_acc0 = e0;
        g_acc1 = e1;
        case (m_phase)
            0: if (e0 || e1) begin
                m_owner = e1;
                m_op    = e1 ? op1 : op0;
                m_a     = e1 ? a1 : a0;
                m_b     = e1 ? b1 : b0;
                m_data  = alu_fn(m_op, m_a, m_b);
                m_last  = e1 ? 1 : 0;
                m_phase = 1;
            end
            1: m_phase = 2;
            2: m_phase = 3;
            default: if ((!m_owner && r0) || (m_owner && r1)) begin
                txn++;
                if (m_owner) g_rsp1 = bus.rsp_data;
                else         g_rsp0 = bus.rsp_data;
                $display("txn %0d cycle %0d port %0d op %h a %h b %h result %h",
                         txn, cyc, m_owner, m_op, m_a, m_b, bus.rsp_data);
                m_phase = 0;
            end
        endcase
        @(negedge clk);
    endtask

    // Issue on one port, stall the response for 'hold' cycles while the other port requests
    task automatic issue(input int port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        int n;
        bit v0, v1;
        v0 = (port == 0); v1 = (port == 1);
        g_acc0 = 1'b0; g_acc1 = 1'b0;
        n = 0;
        while (!(g_acc0 || g_acc1) && n < 8) begin
            step(v0, op, a, b, v1, op, a, b, 1'b0, 1'b0);
            n++;
        end
        repeat (hold + 2) step(v1, OP_ADD, 32'd0, 32'd0, v0, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b0);
        n = 0;
        while (m_phase != 0 && n < 10) begin
            step(v1, OP_ADD, 32'd0, 32'd0, v0, OP_ADD, 32'd0, 32'd0, 1'b1, 1'b1);
            n++;
        end
        step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd1;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev, ng;
        bit p0, p1;
        logic [3:0]  o0, o1;
        logic [31:0] a0, b0, a1, b1;

        drive_idle();
        @(negedge clk);
        do_reset();

        issue(0, OP_ADD, 32'd5, 32'd7, 0);
        check("add_5_7", g_rsp0, 32'd12);

        issue(1, OP_SUB, 32'd10, 32'd3, 5);
        check("sub_10_3", g_rsp1, 32'd7);

        issue(0, OP_SLT, 32'hFFFF_FFFF, 32'd1, 0);
        check("slt_neg", g_rsp0, 32'd1);
        issue(0, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
        check("sltu_big", g_rsp0, 32'd0);
        issue(1, OP_BAD, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        check("bad_op", g_rsp1, 32'd0);

        // Contention: both requesters valid the whole time
        prev = -1; ng = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, OP_OR, 32'hF0, 32'h0F, 1'b1, OP_AND, 32'hFF, 32'h3C, 1'b1, 1'b1);
            if (g_rdy0 || g_rdy1) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
                check("fixed_grant", g_rdy1, 32'd0);
`else
                if (prev >= 0) check("rr_alternate", g_rdy1, (prev == 0));
`endif
                prev = g_rdy1 ? 1 : 0;
                ng++;
            end
        end
        check("contention_or", g_rsp0, 32'hFF);
`ifndef ALU_SHARE_FIXED_PRIO_EN
        check("contention_and", g_rsp1, 32'h3C);
`endif
        repeat (4) step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1, 1'b1);

        // Reset while in EXEC drops the operation
        step(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        do_reset();
        repeat (6) step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1, 1'b1);

        // Randomized traffic; requests are held until accepted
        p0 = 1'b0; p1 = 1'b0;
        o0 = '0; a0 = '0; b0 = '0; o1 = '0; a1 = '0; b1 = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!p0 && $urandom_range(0, 2) == 0) begin
                p0 = 1'b1; o0 = 4'($urandom_range(0, 15)); a0 = rnd_val(); b0 = rnd_val();
            end
            if (!p1 && $urandom_range(0, 2) == 0) begin
                p1 = 1'b1; o1 = 4'($urandom_range(0, 15)); a1 = rnd_val(); b1 = rnd_val();
            end
            step(p0, o0, a0, b0, p1, o1, a1, b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (g_acc0) p0 = 1'b0;
            if (g_acc1) p1 = 1'b0;
            if (i == 700) begin
                do_reset();
                p0 = 1'b0; p1 = 1'b0;
            end
        end
        repeat (8) step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
